// File: rtl/param_up_down_counter.sv
// Up/down counter with a configurable upper limit, wrap or saturate at the limits, and a clamped load.
// Optional sticky boundary flag (ovf port) is built only when UDC_STICKY_OVF_EN is defined.
module param_up_down_counter #(
   parameter int unsigned          WIDTH = 8,
   parameter logic [WIDTH-1:0]     MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             ld,
   input  logic             mode,
   input  logic             sat,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
`ifdef UDC_STICKY_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH-1:0] count_next;
   logic             wrap_next;
   logic             boundary;

   // Terminal count looks at the limit in the currently selected direction.
   assign tc       = mode ? (count == '0) : (count == MAX);
   assign boundary = en && !ld && tc;

   always_comb begin
      count_next = count;
      wrap_next  = 1'b0;
      if (ld) begin
         count_next = (din > MAX) ? MAX : din;
      end else if (en) begin
         wrap_next = tc;
         if (!mode) begin
            if (count == MAX) count_next = sat ? MAX : '0;
            else              count_next = count + WIDTH'(1);
         end else begin
            if (count == '0)  count_next = sat ? '0 : MAX;
            else              count_next = count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

`ifdef UDC_STICKY_OVF_EN
   // A load clears the flag even if a boundary event happens on the same edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)           ovf <= 1'b0;
      else if (ld)       ovf <= 1'b0;
      else if (boundary) ovf <= 1'b1;
   end
`else
   logic unused_boundary;
   assign unused_boundary = boundary;
`endif

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter with WIDTH=8, MAX=9.
// Checks ovf only when UDC_STICKY_OVF_EN is defined for the build.
module tb_param_up_down_counter;

   localparam int WIDTH = 8;
   localparam int MAX   = 9;

   logic             clk = 1'b0;
   logic             clr = 1'b0;
   logic             en = 1'b0;
   logic             ld = 1'b0;
   logic             mode = 1'b0;
   logic             sat = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
`ifdef UDC_STICKY_OVF_EN
   logic             ovf;
`endif

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];

   param_up_down_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
      .clk   (clk),
      .clr   (clr),
      .en    (en),
      .ld    (ld),
      .mode  (mode),
      .sat   (sat),
      .din   (din),
      .count (count),
      .tc    (tc),
      .wrap  (wrap)
`ifdef UDC_STICKY_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic drive(input logic l, input logic [WIDTH-1:0] d, input logic e,
                        input logic m, input logic s);
      ld   = l;
      din  = d;
      en   = e;
      mode = m;
      sat  = s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_q(input string tag);
      logic [WIDTH-1:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 32'(count), 32'(e));
      end
   endtask

   initial begin
      // reset and load while clr held: edges ignored
      #2 clr = 1'b1;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_tc_up", 32'(tc), 0);
      drive(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
      step();
      chk("clr_ignores_ld", 32'(count), 0);
      step();
      chk("clr_hold", 32'(count), 0);
`ifdef UDC_STICKY_OVF_EN
      chk("rst_ovf", 32'(ovf), 0);
`endif
      clr = 1'b0;
      step();
      chk("load7", 32'(count), 7);
      chk("load7_tc", 32'(tc), 0);
      chk("load7_wrap", 32'(wrap), 0);

      // up-wrap from 7
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'd8);
      exp_q.push_back(8'd9);
      exp_q.push_back(8'd0);
      step();
      chk_q("upwrap_e1");
      chk("upwrap_e1_wrap", 32'(wrap), 0);
      step();
      chk_q("upwrap_e2");
      chk("upwrap_e2_tc", 32'(tc), 1);
      chk("upwrap_e2_wrap", 32'(wrap), 0);
      step();
      chk_q("upwrap_e3");
      chk("upwrap_e3_wrap", 32'(wrap), 1);
      chk("upwrap_e3_tc", 32'(tc), 0);
`ifdef UDC_STICKY_OVF_EN
      chk("ovf_set", 32'(ovf), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("ovf_held", 32'(ovf), 1);
      end
      chk("ovf_cnt5", 32'(count), 5);
`endif
      // hold with en=0; din toggles are ignored
      drive(1'b0, 8'd123, 1'b0, 1'b0, 1'b0);
      step();
      chk("hold_wrap", 32'(wrap), 0);
`ifdef UDC_STICKY_OVF_EN
      chk("hold_count", 32'(count), 5);
`else
      chk("hold_count", 32'(count), 0);
`endif
      din = 8'd77;
      step();
      chk("hold_din_change", 32'(count), exp_count_hold());

      // down-saturate from 1
      drive(1'b1, 8'd1, 1'b0, 1'b1, 1'b1);
      step();
      chk("load1", 32'(count), 1);
`ifdef UDC_STICKY_OVF_EN
      chk("ovf_cleared_ld", 32'(ovf), 0);
`endif
      drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      step();
      chk("dsat_e1", 32'(count), 0);
      chk("dsat_e1_wrap", 32'(wrap), 0);
      chk("dsat_e1_tc", 32'(tc), 1);
      step();
      chk("dsat_e2", 32'(count), 0);
      chk("dsat_e2_wrap", 32'(wrap), 1);
      step();
      chk("dsat_e3", 32'(count), 0);
      chk("dsat_e3_wrap", 32'(wrap), 1);

      // down-wrap 0 -> MAX, then direction change takes effect immediately
      sat = 1'b0;
      step();
      chk("dwrap", 32'(count), 9);
      chk("dwrap_wrap", 32'(wrap), 1);
      chk("dwrap_tc_down", 32'(tc), 0);
      mode = 1'b0;
      #1;
      chk("tc_mode_flip", 32'(tc), 1);
      sat = 1'b1;
      step();
      chk("usat_hold", 32'(count), 9);
      chk("usat_wrap", 32'(wrap), 1);
      mode = 1'b1;
      step();
      chk("dir_change", 32'(count), 8);
      chk("dir_change_wrap", 32'(wrap), 0);

      // load clamp and priority over en
      drive(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
      step();
      chk("clamp200", 32'(count), 9);
      chk("clamp200_wrap", 32'(wrap), 0);
      step();
      chk("ld_over_en_at_max", 32'(count), 9);
      chk("ld_over_en_wrap", 32'(wrap), 0);
      din = 8'd10;
      step();
      chk("clamp10", 32'(count), 9);
      din = 8'd255;
      step();
      chk("clamp255", 32'(count), 9);
      din = 8'd0;
      step();
      chk("load0", 32'(count), 0);

      // async clear mid-operation
      drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      step();
      chk("pre_clr", 32'(count), 6);
      #3 clr = 1'b1;
      #1;
      chk("async_clr", 32'(count), 0);
      chk("async_clr_wrap", 32'(wrap), 0);
      step();
      chk("clr_held", 32'(count), 0);
      clr = 1'b0;
      mode = 1'b1;
      #1;
      chk("post_clr_tc", 32'(tc), 1);
      step();
      chk("post_clr_dwrap", 32'(count), 9);
      chk("post_clr_wrap", 32'(wrap), 1);
      en = 1'b0;
      step();
      chk("wrap_one_cycle", 32'(wrap), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // count expected after the en=0 hold steps above
   function automatic int exp_count_hold();
`ifdef UDC_STICKY_OVF_EN
      return 5;
`else
      return 0;
`endif
   endfunction

endmodule

// File: doc/param_up_down_counter.md
PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count, din and limit width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, giving the upper count limit (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port ld, input, 1 bit: synchronous load strobe.
REQ-007 The block SHALL have port mode, input, 1 bit: direction select, 0 = up, 1 = down.
REQ-008 The block SHALL have port sat, input, 1 bit: boundary policy, 0 = wrap, 1 = saturate.
REQ-009 The block SHALL have port din, input, WIDTH bits: load value.
REQ-010 The block SHALL have port count, output, WIDTH bits: registered count value.
REQ-011 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-012 The block SHALL have port wrap, output, 1 bit: registered boundary-event pulse.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky boundary flag; present only under the macro in REQ-029.

Function
REQ-014 Per rising clk edge, priority SHALL be clr (async), then ld, then en, then hold.
REQ-015 Load SHALL set count <= din if din <= MAX, else count <= MAX (clamp); mode, sat and en are ignored in that cycle.
REQ-016 en=1 with ld=0, mode=0 and count < MAX SHALL give count <= count+1.
REQ-017 en=1 with ld=0, mode=1 and count > 0 SHALL give count <= count-1.
REQ-018 Up-count at count == MAX SHALL give count <= 0 when sat=0, and hold MAX when sat=1.
REQ-019 Down-count at count == 0 SHALL give count <= MAX when sat=0, and hold 0 when sat=1.
REQ-020 en=0 with ld=0 SHALL hold count, with wrap <= 0.
REQ-021 tc SHALL be high exactly when (mode=0 and count == MAX) or (mode=1 and count == 0), independent of en, ld and sat.
REQ-022 wrap SHALL go high for exactly one cycle, in the cycle after any edge where en=1, ld=0 and tc=1 (a boundary event, whether wrapped or saturated), and be 0 otherwise.
REQ-023 A direction change SHALL take effect on the same edge; no pipeline delay.
REQ-024 All arithmetic SHALL be modulo 2**WIDTH internally; count SHALL never exceed MAX.
REQ-025 Outputs SHALL not glitch due to din changes when ld=0.

Reset
REQ-026 Asserting clr at any time SHALL immediately force count=0, wrap=0 and ovf=0, including mid-count or mid-load.
REQ-027 While clr=1, all edges SHALL be ignored.
REQ-028 After clr deasserts, the first active edge SHALL follow REQ-014; tc then reflects count=0 with the current mode.

Configuration
REQ-029 Macro UDC_STICKY_OVF_EN SHALL gate the ovf feature.
REQ-030 With UDC_STICKY_OVF_EN defined: ovf SHALL set on any boundary event (REQ-022 condition), hold until clr or a ld edge clears it, with ld clearing taking priority over a simultaneous set.
REQ-031 Without UDC_STICKY_OVF_EN: the ovf port SHALL not exist and no ovf register SHALL be synthesised; all other behaviour SHALL be identical.

Verification (WIDTH=8, MAX=9 unless noted)
REQ-032 Reset and load: clr pulse, then ld=1 with din=7 -> count=0 during clr; count=7 after the edge; tc=0.
REQ-033 Up-wrap: count=7, mode=0, sat=0, en=1 for 3 edges -> 8, 9 (tc=1), then 0 with wrap=1 for one cycle.
REQ-034 Down-saturate: count=1, mode=1, sat=1, en=1 for 3 edges -> 0, 0, 0; tc=1; wrap pulses on the 2nd and 3rd edges.
REQ-035 Load clamp and priority: din=200, ld=1, en=1, mode=0 -> count=9 (not 10, not 200); ovf cleared if built.
REQ-036 Async reset mid-operation: count=5, en=1, clr asserted between edges -> count=0 immediately, before the next clk edge; holds 0 while clr=1.
REQ-037 Sticky ovf (macro defined): an up-wrap from 9 -> ovf=1 held across 5 further counts; next ld -> ovf=0; build without macro compiles with no ovf port.
